// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RISC-V control unit.
//   state_t        - FSM states; the encoding is exported on the debug state port
//   OP_*           - the opcodes the controller recognises
//   aluop_t        - the operation class the FSM hands to the ALU decoder
//   ALU_*          - ALUControl encodings understood by the datapath ALU
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: turns the FSM's ALU operation class plus instruction fields
// into the ALUControl code.
//   alu_op      in  2  operation class from the FSM
//   op5         in  1  opcode bit 5 (set for R-type, clear for I-type)
//   funct3      in  3  instruction funct3
//   funct7b5    in  1  instruction bit 30
//   alu_control out 3  ALU operation
module aludec
    import mc_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type uses bit 30 to select sub; addi ignores it.
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM that sequences fetch, decode and
// per-class execute/writeback states, plus the immediate-format decoder.
//   clk, reset (async, active-low)
//   op, funct3, funct7b5, Zero          - instruction fields and ALU flag
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegWrite        - datapath controls
//   state                               - current FSM state (debug)
module mc_controller
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic               RegWrite,
    output logic [STATE_W-1:0] state
);

    state_t cur_state;
    state_t nxt_state;

    aluop_t alu_op;
    logic   pc_update;
    logic   branch;
    logic   ir_write;
    logic   reg_write;
    logic   mem_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_state <= FETCH;
        else        cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = FETCH;
        case (cur_state)
            FETCH: nxt_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: nxt_state = MEMADR;
                    OP_RTYPE:          nxt_state = EXECUTER;
                    OP_ITYPE:          nxt_state = EXECUTEI;
                    OP_JAL:            nxt_state = JAL;
                    OP_BEQ:            nxt_state = BEQ;
                    default:           nxt_state = FETCH;
                endcase
            end
            MEMADR:   nxt_state = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt_state = MEMWB;
            MEMWB:    nxt_state = FETCH;
            MEMWRITE: nxt_state = FETCH;
            EXECUTER: nxt_state = ALUWB;
            EXECUTEI: nxt_state = ALUWB;
            JAL:      nxt_state = ALUWB;
            ALUWB:    nxt_state = FETCH;
            BEQ:      nxt_state = FETCH;
            default:  nxt_state = FETCH;
        endcase
    end

    // Moore outputs; selects not used by a state are parked at 0.
    always_comb begin
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = ALUOP_ADD;
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        case (cur_state)
            FETCH: begin
                ir_write  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: begin
                AdrSrc = 1'b0;
            end
        endcase
    end

    // Enables are gated by reset directly so nothing writes while reset is
    // held, even though the state register already reads FETCH.
    assign PCWrite  = reset & (pc_update | (branch & Zero));
    assign IRWrite  = reset & ir_write;
    assign RegWrite = reset & reg_write;
    assign MemWrite = reset & mem_write;

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_LOAD, OP_ITYPE: ImmSrc = 2'b00;
            OP_STORE:          ImmSrc = 2'b01;
            OP_BEQ:            ImmSrc = 2'b10;
            OP_JAL:            ImmSrc = 2'b11;
            default:           ImmSrc = 2'b00;
        endcase
    end

    aludec u_aludec (
        .alu_op      (alu_op),
        .op5         (op[5]),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

    assign state = STATE_W'(cur_state);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instructions, a random instruction stream
// and a mid-instruction reset, each cycle compared against a reference model
// that derives the state walk per instruction class and the control outputs
// from the per-state table.
module tb_mc_controller;
    import mc_pkg::*;

    localparam int W = 20;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    mc_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .state      (state)
    );

    logic [W-1:0] obs_vec;
    assign obs_vec = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                      ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite};

    // scoreboard
    logic [W-1:0] exp_q[$];
    state_t       role_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    // reference model
    function automatic logic [2:0] ref_alu_funct(input logic [6:0] o, input logic [2:0] f3,
                                                 input logic f7);
        case (f3)
            3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] ref_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [W-1:0] ref_vec(input state_t s, input logic [6:0] o,
                                             input logic [2:0] f3, input logic f7,
                                             input logic z, input logic in_reset);
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, asa, asb;
        logic [2:0] aluc;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
        rs = 2'b00; asa = 2'b00; asb = 2'b00; aluc = 3'b000;
        case (s)
            FETCH:    begin irw = 1; asb = 2'b10; rs = 2'b10; pcw = 1; end
            DECODE:   begin asa = 2'b01; asb = 2'b01; end
            MEMADR:   begin asa = 2'b10; asb = 2'b01; end
            MEMREAD:  begin adr = 1; end
            MEMWRITE: begin adr = 1; mw = 1; end
            MEMWB:    begin rs = 2'b01; rw = 1; end
            EXECUTER: begin asa = 2'b10; aluc = ref_alu_funct(o, f3, f7); end
            EXECUTEI: begin asa = 2'b10; asb = 2'b01; aluc = ref_alu_funct(o, f3, f7); end
            ALUWB:    begin rw = 1; end
            JAL:      begin asa = 2'b01; asb = 2'b10; pcw = 1; end
            BEQ:      begin asa = 2'b10; aluc = 3'b001; pcw = z; end
            default:  begin end
        endcase
        if (in_reset) begin
            pcw = 0; irw = 0; rw = 0; mw = 0;
        end
        return {4'(s), pcw, adr, mw, irw, rs, asa, asb, aluc, ref_imm(o), rw};
    endfunction

    // State walk for one instruction, chosen by instruction class.
    task automatic build_seq(input logic [6:0] o);
        case (o)
            7'b0000011: role_q = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
            7'b0100011: role_q = '{FETCH, DECODE, MEMADR, MEMWRITE};
            7'b0110011: role_q = '{FETCH, DECODE, EXECUTER, ALUWB};
            7'b0010011: role_q = '{FETCH, DECODE, EXECUTEI, ALUWB};
            7'b1101111: role_q = '{FETCH, DECODE, JAL, ALUWB};
            7'b1100011: role_q = '{FETCH, DECODE, BEQ};
            default:    role_q = '{FETCH, DECODE};
        endcase
    endtask

    // driver: zmode 0/1 forces Zero, 2 randomises it each cycle;
    // ncyc > 0 stops after that many cycles, leaving time just past the check.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zmode, input int ncyc);
        int last;
        build_seq(o);
        last = (ncyc > 0) ? ncyc : role_q.size();
        for (int i = 0; i < last; i++) begin
            op = o; funct3 = f3; funct7b5 = f7;
            Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            exp_q.push_back(ref_vec(role_q[i], o, f3, f7, Zero, 1'b0));
            @(negedge clk);
            check($sformatf("op%07b_%s", o, role_q[i].name()), obs_vec, exp_q.pop_front());
            if (!(ncyc > 0 && i == last - 1)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    function automatic logic known_op(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                         7'b1101111, 7'b1100011};
    endfunction

    initial begin
        logic [6:0] rop;
        logic [6:0] ops[6];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};

        // reset held
        reset = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1;
        #2;
        check("reset_async", obs_vec, ref_vec(FETCH, op, funct3, funct7b5, Zero, 1'b1));
        repeat (2) begin
            @(negedge clk);
            check("reset_held", obs_vec, ref_vec(FETCH, op, funct3, funct7b5, Zero, 1'b1));
        end
        @(posedge clk);
        #1 reset = 1'b1;

        // directed instructions
        run_instr(7'b0000011, 3'b010, 1'b0, 2, 0);   // lw
        run_instr(7'b0100011, 3'b010, 1'b0, 2, 0);   // sw
        run_instr(7'b0110011, 3'b000, 1'b1, 2, 0);   // sub
        run_instr(7'b0010011, 3'b000, 1'b1, 2, 0);   // addi, bit 30 ignored
        run_instr(7'b0110011, 3'b010, 1'b0, 2, 0);   // slt
        run_instr(7'b0110011, 3'b110, 1'b0, 2, 0);   // or
        run_instr(7'b0010011, 3'b111, 1'b0, 2, 0);   // andi
        run_instr(7'b1100011, 3'b000, 1'b0, 1, 0);   // beq taken
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0);   // beq not taken
        run_instr(7'b1101111, 3'b000, 1'b0, 2, 0);   // jal
        run_instr(7'b1111111, 3'b000, 1'b0, 2, 0);   // unknown

        // random instruction stream
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do rop = 7'($urandom); while (known_op(rop));
            end else begin
                rop = ops[$urandom_range(0, 5)];
            end
            run_instr(rop, 3'($urandom), 1'($urandom), 2, 0);
        end

        // reset during MEMREAD of a load
        run_instr(7'b0000011, 3'b010, 1'b0, 2, 4);
        #2 reset = 1'b0;
        #1 check("reset_in_memread", obs_vec, ref_vec(FETCH, op, funct3, funct7b5, Zero, 1'b1));
        repeat (2) begin
            @(posedge clk);
            #1 check("reset_hold_post_edge", obs_vec,
                     ref_vec(FETCH, op, funct3, funct7b5, Zero, 1'b1));
        end
        @(posedge clk);
        #1 reset = 1'b1;
        run_instr(7'b0110011, 3'b111, 1'b0, 2, 0);
        run_instr(7'b0100011, 3'b010, 1'b0, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
